// File: rtl/_skid_buf_if.sv
// ---------------------------------------------------------------------------
// _skid_buf_if
//
// Purpose
//   Bundles the upstream (in_*) and downstream (out_*) valid/ready channels
//   of the two-entry skid buffer so they travel as one port.
//
// Parameters
//   n          data width in bits (default `WORD_LENGTH, which falls back
//              to 32 when the including build does not define it)
//
// Signals
//   in_valid   upstream presents a word on in_data
//   in_data    upstream word
//   in_ready   buffer can accept a word this cycle
//   out_valid  out_data holds a valid word
//   out_data   oldest buffered word
//   out_ready  downstream consumes out_data this cycle
//
// Modports
//   slave      the buffer's view (accepts in_*, produces out_*)
//   master     the surrounding logic's view (produces in_*, consumes out_*)
//
// Handshake rule (both channels): a word moves on a rising clock edge
// exactly when valid and ready are both 1 in the cycle before that edge.
// A producer that raises valid keeps its data stable until the transfer;
// ready may be 0 or 1 independently of valid and never waits for it.
// ---------------------------------------------------------------------------
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

interface _skid_buf_if #(
  parameter int n = `WORD_LENGTH
);

  logic         in_valid;
  logic [n-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [n-1:0] out_data;
  logic         out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/_skid_buf.sv
// ---------------------------------------------------------------------------
// _skid_buf
//
// Purpose
//   Two-entry skid buffer between a valid/ready producer and a consumer
//   (out_data feeds a downstream _mux2 input). Words leave in acceptance
//   order, one word per cycle is sustained when both sides are always
//   ready, and in_ready is a pure function of registered state, so there
//   is no combinational path from out_ready back to in_ready.
//
// Parameters
//   n          data width in bits (default `WORD_LENGTH)
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   flush      discard every buffered word (only with SKID_BUF_FLUSH_EN)
//   bus        _skid_buf_if.slave: in_valid/in_data/in_ready and
//              out_valid/out_data/out_ready
//   dbg_state  current FSM state (0 EMPTY, 1 ONE, 2 FULL)
//
// Configuration
//   SKID_BUF_FLUSH_EN  when defined, adds the flush port and its logic.
//                      When undefined the port does not exist.
//
// Storage
//   main  holds the oldest word and drives out_data directly.
//   skid  catches the word accepted while main is still waiting for the
//         consumer; it is only meaningful in FULL.
//
// State  | words | in_ready | out_valid
//   EMPTY|   0   |    1     |    0
//   ONE  |   1   |    1     |    1
//   FULL |   2   |    0     |    1
// ---------------------------------------------------------------------------
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module _skid_buf #(
  parameter int n = `WORD_LENGTH
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SKID_BUF_FLUSH_EN
  input  logic        flush,
`endif
  _skid_buf_if.slave  bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_d;

  logic [n-1:0] main;
  logic [n-1:0] main_d;
  logic [n-1:0] skid;
  logic [n-1:0] skid_d;

  logic         in_rdy;
  logic         out_vld;
  logic         in_fire;
  logic         out_fire;
  logic         flush_req;

  // -------------------------------------------------------------------------
  // Flush request. Tied low when the feature is not built so the next-state
  // logic stays identical in both builds.
  // -------------------------------------------------------------------------
`ifdef SKID_BUF_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Transfers use the registered-state handshake signals only.
  assign in_fire  = bus.in_valid & in_rdy;
  assign out_fire = out_vld & bus.out_ready;

  // -------------------------------------------------------------------------
  // Process 1: state and data registers.
  // Reset clears both data registers as well as the state so the cycle
  // after reset presents out_data = 0.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      main  <= '0;
      skid  <= '0;
    end else begin
      state <= state_d;
      main  <= main_d;
      skid  <= skid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Process 2: next state and next register contents.
  // Registers keep their value unless a transition below loads them, so
  // contents left over in EMPTY simply persist.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    main_d  = main;
    skid_d  = skid;

    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = bus.in_data;
        end
      end

      ONE: begin
        if (in_fire && out_fire) begin
          // Consumer takes main while the producer refills it: stay in ONE.
          main_d = bus.in_data;
        end else if (in_fire) begin
          // main is still owed to the consumer, so the new word skids.
          state_d = FULL;
          skid_d  = bus.in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end

      FULL: begin
        // in_ready is 0 here, so only the output side can move.
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid;
        end
      end

      default: begin
        state_d = EMPTY;
      end
    endcase

    // Flush wins over any transfer in the same cycle; the data registers
    // keep whatever they held, only the occupancy is discarded.
    if (flush_req) begin
      state_d = EMPTY;
      main_d  = main;
      skid_d  = skid;
    end
  end

  // -------------------------------------------------------------------------
  // Process 3: outputs, decoded from registered state only.
  // -------------------------------------------------------------------------
  always_comb begin
    in_rdy  = 1'b1;
    out_vld = 1'b0;

    unique case (state)
      EMPTY: begin
        in_rdy  = 1'b1;
        out_vld = 1'b0;
      end
      ONE: begin
        in_rdy  = 1'b1;
        out_vld = 1'b1;
      end
      FULL: begin
        in_rdy  = 1'b0;
        out_vld = 1'b1;
      end
      default: begin
        in_rdy  = 1'b1;
        out_vld = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = main;
  assign dbg_state     = state;

endmodule

// File: tb/tb__skid_buf.sv
module tb__skid_buf;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_sig = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  _skid_buf_if #(.n(W)) bus ();

  _skid_buf #(.n(W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SKID_BUF_FLUSH_EN
    .flush     (flush_sig),
`endif
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
  end

  // Watchdog: the run must always terminate.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; checks happen on the
  // falling edge, when both inputs and outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Words are queued when accepted and compared in order when consumed.
  // Occupancy flags are checked against the queue depth every cycle.
  always @(negedge clk) begin
    logic [W-1:0] exp_w;
    if (rst || flush_sig) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (bus.out_valid !== (exp_q.size() > 0)) begin
        errors++;
        $display("FAIL sb_out_valid: got %b expected %b", bus.out_valid, exp_q.size() > 0);
      end
      checks++;
      if (bus.in_ready !== (exp_q.size() < 2)) begin
        errors++;
        $display("FAIL sb_in_ready: got %b expected %b", bus.in_ready, exp_q.size() < 2);
      end
      if (prev_stall) begin
        checks++;
        if (bus.out_data !== prev_data) begin
          errors++;
          $display("FAIL sb_stable: got %h expected %h", bus.out_data, prev_data);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got %h expected no word", bus.out_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (bus.out_data !== exp_w) begin
            errors++;
            $display("FAIL sb_order: got %h expected %h", bus.out_data, exp_w);
          end
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
        exp_q.push_back(bus.in_data);
      prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      prev_data  = bus.out_data;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick();
    rst = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    probe();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 32'h0) begin
      errors++; $display("FAIL reset_out_data: got %h expected 00000000", bus.out_data);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
  endtask

  task automatic test_single();
    tick();
    drive(1'b1, 32'h00000011, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    probe();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11) begin
      errors++;
      $display("FAIL single_out: got v=%b d=%h expected v=1 d=00000011", bus.out_valid, bus.out_data);
    end
    tick();
    probe();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got %b expected 0", bus.out_valid);
    end
    tick();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'hA1, 1'b0);
    tick();
    drive(1'b1, 32'hA2, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      probe();
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_data !== 32'hA1 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: got r=%b v=%b d=%h expected r=0 v=1 d=000000a1",
                 bus.in_ready, bus.out_valid, bus.out_data);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    probe();
    checks++;
    if (bus.out_data !== 32'hA1) begin
      errors++; $display("FAIL bp_pop1: got %h expected 000000a1", bus.out_data);
    end
    tick();
    probe();
    checks++;
    if (bus.out_data !== 32'hA2 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_pop2: got r=%b v=%b d=%h expected r=1 v=1 d=000000a2",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    tick();
    probe();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty: got %b expected 0", bus.out_valid);
    end
    tick();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1);
      probe();
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_in_ready: got %b expected 1 (cycle %0d)", bus.in_ready, i);
      end
      if (i > 1) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== W'(i - 1)) begin
          errors++;
          $display("FAIL stream_out: got v=%b d=%h expected v=1 d=%h", bus.out_valid, bus.out_data, W'(i - 1));
        end
      end
      tick();
    end
    drive(1'b0, '0, 1'b1);
    probe();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd8) begin
      errors++; $display("FAIL stream_last: got v=%b d=%h expected v=1 d=00000008", bus.out_valid, bus.out_data);
    end
    tick();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 32'h5, 1'b0);
    tick();
    drive(1'b1, 32'h6, 1'b1);
    probe();
    checks++;
    if (bus.out_data !== 32'h5) begin
      errors++; $display("FAIL simul_pre: got %h expected 00000005", bus.out_data);
    end
    tick();
    drive(1'b0, '0, 1'b0);
    probe();
    checks++;
    if (dbg_state !== 2'd1 || bus.out_data !== 32'h6) begin
      errors++; $display("FAIL simul_post: got s=%0d d=%h expected s=1 d=00000006", dbg_state, bus.out_data);
    end
    tick();
    bus.out_ready = 1'b1;
    tick();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'hC1, 1'b0);
    tick();
    drive(1'b1, 32'hC2, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'hC3, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      probe();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
        errors++;
        $display("FAIL rstmid_out: got v=%b d=%h expected v=0 d=00000000", bus.out_valid, bus.out_data);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0);
  endtask

`ifdef SKID_BUF_FLUSH_EN
  task automatic test_flush();
    drive(1'b1, 32'hB1, 1'b0);
    tick();
    drive(1'b1, 32'hB2, 1'b0);
    tick();
    drive(1'b1, 32'hB3, 1'b0);
    flush_sig = 1'b1;
    tick();
    flush_sig = 1'b0;
    drive(1'b0, '0, 1'b1);
    probe();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: got v=%b r=%b expected v=0 r=1", bus.out_valid, bus.in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      probe();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_no_b3: got v=%b d=%h expected v=0", bus.out_valid, bus.out_data);
      end
    end
    tick();
    drive(1'b0, '0, 1'b0);
  endtask
`endif

  task automatic test_random();
    int guard;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0));
      tick();
    end
    drive(1'b0, '0, 1'b1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      tick();
      guard++;
    end
    probe();
    checks++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: got %0d words left v=%b expected 0 words v=0", exp_q.size(), bus.out_valid);
    end
    tick();
    drive(1'b0, '0, 1'b0);
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_simultaneous();
    test_reset_mid();
`ifdef SKID_BUF_FLUSH_EN
    test_flush();
`endif
    test_random();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/_skid_buf.md
_SKID_BUF -- requirements
Module: _skid_buf

Interface
REQ-001 Parameter: n, default WORD_LENGTH, data width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream presents a word on in_data.
REQ-005 in_data  input  n  upstream word.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 out_valid  output  1  out_data holds a valid word.
REQ-008 out_data  output  n  oldest buffered word, feeding a downstream _mux2 input.
REQ-009 out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 flush  input  1  discard all buffered words; present only when SKID_BUF_FLUSH_EN is defined.

Function
REQ-011 Two n-bit registers SHALL be used: main (drives out_data) and skid (overflow).
REQ-012 State machine states SHALL be EMPTY (0 words), ONE (1 word, in main) and FULL (2 words).
REQ-013 An input transfer (in_fire) SHALL occur when in_valid and in_ready are both 1; an output transfer (out_fire) SHALL occur when out_valid and out_ready are both 1.
REQ-014 in_ready SHALL be 1 iff state != FULL and SHALL depend on registered state only; there is no combinational path from out_ready.
REQ-015 out_valid SHALL be 1 iff state != EMPTY; out_data SHALL equal main.
REQ-016 EMPTY + in_fire -> ONE, main <= in_data; otherwise stay EMPTY.
REQ-017 ONE + in_fire + out_fire -> ONE, main <= in_data.
REQ-018 ONE + in_fire only -> FULL, skid <= in_data.
REQ-019 ONE + out_fire only -> EMPTY.
REQ-020 FULL + out_fire -> ONE, main <= skid; FULL with no out_fire holds all state.
REQ-021 Latency: a word accepted in cycle N SHALL be visible on out_data with out_valid=1 in cycle N+1 when the buffer was EMPTY.
REQ-022 Throughput: sustained one word per cycle with in_valid=out_ready=1 continuously; no bubbles inserted.
REQ-023 Words SHALL leave in acceptance order; none dropped or duplicated.
REQ-024 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Register contents in EMPTY are don't-care to consumers but SHALL hold their last value.

Reset
REQ-026 rst=1 at a rising edge SHALL force state EMPTY, main=0, skid=0, regardless of in_valid/out_ready/flush.
REQ-027 In the cycle after reset: in_ready=1, out_valid=0, out_data=0.
REQ-028 Reset mid-operation SHALL discard all buffered words; nothing buffered before reset appears afterwards.

Configuration
REQ-029 Macro SKID_BUF_FLUSH_EN SHALL gate the flush port and logic.
REQ-030 With SKID_BUF_FLUSH_EN defined: flush=1 SHALL force state EMPTY next cycle, taking priority over any simultaneous in_fire or out_fire; main/skid hold value; rst takes priority over flush.
REQ-031 With SKID_BUF_FLUSH_EN undefined: the flush port SHALL not exist and behaviour is REQ-011..REQ-028 only.

Verification (n=32)
REQ-032 Reset: rst=1 one cycle with in_valid=1, in_data=0xDEADBEEF -> next cycle in_ready=1, out_valid=0, out_data=0.
REQ-033 Single word: EMPTY, in_data=0x00000011 valid one cycle, out_ready=1 -> out_valid=1, out_data=0x11 next cycle, out_valid=0 the cycle after.
REQ-034 Back-pressure: out_ready=0, push 0xA1, 0xA2 -> in_ready=0 after second push, out_data=0xA1 held; release out_ready -> 0xA1 then 0xA2 on consecutive cycles, in_ready=1 after first pop.
REQ-035 Streaming: in_valid=out_ready=1 for 8 cycles, data 1..8 -> out_data 1..8 on 8 consecutive cycles, one cycle late, in_ready constant 1.
REQ-036 Simultaneous in/out in ONE: main=0x5, push 0x6 with out_ready=1 -> state ONE, out_data=0x6 next cycle.
REQ-037 Flush (SKID_BUF_FLUSH_EN): FULL with 0xB1, 0xB2, flush=1 plus in_valid=1 data 0xB3 -> next cycle out_valid=0, in_ready=1; 0xB3 never emitted.
